// File: rtl/handshake_rr_arbiter.sv
// N-to-1 round-robin arbiter for valid/ready streams with a registered output stage.
// Optional packet lock (in_last/out_last, ARB/LOCK FSM) enabled by HANDSHAKE_ARB_LAST_LOCK_EN.
module handshake_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_BITS = 8,
  localparam int SRC_BITS = $clog2(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic [NUM_PORTS-1:0]           in_valid,
  output logic [NUM_PORTS-1:0]           in_ready,
  input  logic [NUM_PORTS*DATA_BITS-1:0] in_data,
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
  input  logic [NUM_PORTS-1:0]           in_last,
  output logic                           out_last,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_BITS-1:0]           out_data,
  output logic [SRC_BITS-1:0]            out_src
);

  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic [SRC_BITS-1:0]  out_src_q, out_src_d;
  logic [SRC_BITS-1:0]  last_grant_q, last_grant_d;

  logic                 load_en;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  logic [SRC_BITS-1:0]  win_idx;
  logic                 win_any;
  int                   idx;

`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
  // state | meaning
  // ARB   | every beat arbitrated round-robin
  // LOCK  | grant pinned to last_grant until its in_last beat is accepted
  typedef enum logic {ARB, LOCK} state_t;
  state_t state_q, state_d;
  logic   out_last_q, out_last_d;
`endif

  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    req = in_valid;
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
    if (state_q == LOCK) req = in_valid & (NUM_PORTS'(1) << last_grant_q);
`endif
    win_idx = '0;
    win_any = 1'b0;
    idx     = 0;
    // Walk from the farthest candidate back so the nearest requester after last_grant wins.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % NUM_PORTS;
      if (req[idx]) begin
        win_any = 1'b1;
        win_idx = SRC_BITS'(idx);
      end
    end
    grant = '0;
    if (win_any) grant[win_idx] = 1'b1;
  end

  assign in_ready = (load_en && !arst) ? grant : '0;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
    out_last_d   = out_last_q;
    state_d      = state_q;
`endif
    if (load_en) begin
      if (win_any) begin
        out_valid_d  = 1'b1;
        out_data_d   = in_data[int'(win_idx)*DATA_BITS +: DATA_BITS];
        out_src_d    = win_idx;
        last_grant_d = win_idx;
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
        out_last_d   = in_last[win_idx];
        if (state_q == ARB && !in_last[win_idx]) state_d = LOCK;
        else if (state_q == LOCK && in_last[win_idx]) state_d = ARB;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      last_grant_q <= SRC_BITS'(NUM_PORTS - 1);
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
      out_last_q   <= 1'b0;
      state_q      <= ARB;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
      out_last_q   <= out_last_d;
      state_q      <= state_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench for handshake_rr_arbiter: directed scenarios plus randomized traffic
// compared against a distance-based round-robin reference model.
module tb_handshake_rr_arbiter;
  localparam int NP = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic [NP-1:0]   in_valid = '0;
  logic [NP-1:0]   in_ready;
  logic [NP*DW-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
  logic [NP-1:0]   in_last = '0;
  logic            out_last;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state
  bit        m_valid;
  logic [7:0] m_data;
  int        m_src;
  int        m_lg;
  bit        m_lock;
  bit        m_last;

  handshake_rr_arbiter #(.NUM_PORTS(NP), .DATA_BITS(DW)) dut (
    .clk(clk), .arst(arst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Winner = requesting port at the smallest rotational distance past the last grant.
  function automatic int pick(input logic [NP-1:0] v, input int lg);
    int best = -1;
    int bd = NP;
    for (int i = 0; i < NP; i++) begin
      if (v[i]) begin
        int d = (i - lg - 1 + 2*NP) % NP;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 8'h00; m_src = 0; m_lg = NP-1; m_lock = 0; m_last = 0;
  endtask

  task automatic set_data(input int p, input logic [7:0] d);
    in_data[p*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    arst = 1'b1;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_src", {30'd0, out_src}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    arst = 1'b0;
    model_reset();
  endtask

  task automatic tick();
    logic [NP-1:0] v;
    logic [NP-1:0] exp_rdy;
    bit load;
    int w;
    #1;
    v = in_valid;
    if (m_lock) v = v & (NP'(1) << m_lg);
    w = pick(v, m_lg);
    load = !m_valid || out_ready;
    exp_rdy = (load && w >= 0) ? (NP'(1) << w) : '0;
    chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    if (load) begin
      if (w >= 0) begin
        m_valid = 1;
        m_data = in_data[w*DW +: DW];
        m_src = w;
        m_lg = w;
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
        m_last = in_last[w];
        if (!m_lock && !in_last[w]) m_lock = 1;
        else if (m_lock && in_last[w]) m_lock = 0;
`endif
      end else begin
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_data", {24'd0, out_data}, {24'd0, m_data});
    chk("out_src", {30'd0, out_src}, 32'(m_src));
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
    chk("out_last", {31'd0, out_last}, {31'd0, m_last});
`endif
  endtask

  initial begin
    logic [7:0] seq2 [5];
    int         src2 [5];
    seq2 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
    src2 = '{0, 1, 2, 3, 0};
    model_reset();
    #12;
    in_valid = 4'b1111;
    #1;
    chk("in_ready_held_in_reset", {28'd0, in_ready}, 32'd0);
    in_valid = '0;
    arst = 1'b0;

    // 1: single port, two beats
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b0100; set_data(2, 8'hA1);
    tick();
    chk("t1_data0", {24'd0, out_data}, 32'hA1);
    chk("t1_src0", {30'd0, out_src}, 32'd2);
    set_data(2, 8'hB2);
    tick();
    chk("t1_data1", {24'd0, out_data}, 32'hB2);
    chk("t1_src1", {30'd0, out_src}, 32'd2);
    in_valid = '0;
    tick();
    chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);

    // 2: all ports valid, fair rotation
    do_reset();
    out_ready = 1'b1;
    set_data(0, 8'h10); set_data(1, 8'h20); set_data(2, 8'h30); set_data(3, 8'h40);
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_data", {24'd0, out_data}, {24'd0, seq2[i]});
      chk("t2_src", {30'd0, out_src}, 32'(src2[i]));
    end

    // 3: backpressure hold
    in_valid = 4'b0001; set_data(0, 8'hC3);
    tick();
    chk("t3_load", {24'd0, out_data}, 32'hC3);
    out_ready = 1'b0;
    in_valid = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_data", {24'd0, out_data}, 32'hC3);
      chk("t3_hold_rdy", {28'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_resume_src", {30'd0, out_src}, 32'd1);
    tick();
    chk("t3_resume_src2", {30'd0, out_src}, 32'd0);

    // 4: wrap past idle port 0
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b0010;
    tick();
    chk("t4_first", {30'd0, out_src}, 32'd1);
    in_valid = 4'b1010;
    tick();
    chk("t4_second", {30'd0, out_src}, 32'd3);
    tick();
    chk("t4_third", {30'd0, out_src}, 32'd1);

    // 5: async reset mid-transfer
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b0001; set_data(0, 8'hD4);
    tick();
    chk("t5_loaded", {24'd0, out_data}, 32'hD4);
    out_ready = 1'b0; in_valid = '0;
    #2;
    arst = 1'b1;
    #1;
    chk("t5_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_async_data", {24'd0, out_data}, 32'd0);
    #2;
    arst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    in_valid = 4'b1001;
    tick();
    chk("t5_after_src", {30'd0, out_src}, 32'd0);

`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
    // 6: packet lock
    begin
      logic [7:0] pk [3];
      logic [7:0] exp_d [4];
      int         exp_s [4];
      int         p0 = 0;
      pk = '{8'hAB, 8'hCD, 8'hEF};
      exp_d = '{8'hAB, 8'hCD, 8'hEF, 8'h55};
      exp_s = '{0, 0, 0, 1};
      do_reset();
      out_ready = 1'b1;
      set_data(1, 8'h55);
      for (int i = 0; i < 4; i++) begin
        in_valid = {2'b00, 1'b1, p0 < 3};
        set_data(0, (p0 < 3) ? pk[p0] : 8'h00);
        in_last = {2'b00, 1'b1, p0 == 2};
        tick();
        if (out_valid && out_src == 2'd0) p0++;
        chk("t6_data", {24'd0, out_data}, {24'd0, exp_d[i]});
        chk("t6_src", {30'd0, out_src}, 32'(exp_s[i]));
        chk("t6_last", {31'd0, out_last}, {31'd0, (i >= 2)});
      end
      in_last = '0;
    end
`endif

    // randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      in_valid = NP'($urandom);
      in_data = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef HANDSHAKE_ARB_LAST_LOCK_EN
      in_last = NP'($urandom);
`endif
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
